pixel_byte_assembler: RTL and testbench

//  Write-side producer of 24-bit pixels for the VGA serial display frame buffer.

---
 rtl/pixel_byte_assembler_if.sv | 36 +++
 rtl/pixel_byte_assembler.sv | 121 ++++++++++++
 tb/tb_pixel_byte_assembler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_byte_assembler_if.sv
// Byte-in / pixel-write bus of the frame-buffer write producer.
// The slave side is the assembler; the master side feeds bytes and observes writes.
interface pixel_byte_assembler_if #(
    parameter int ADDR_W = 17
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              frame_sync;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              frame_done;
    logic              busy;

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_sync,
        output wr_en,
        output wr_addr,
        output wr_data,
        output frame_done,
        output busy
    );

    modport master (
        output rx_data,
        output rx_valid,
        output frame_sync,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  frame_done,
        input  busy
    );
endinterface

// File: rtl/pixel_byte_assembler.sv
// Packs R,G,B UART bytes into {B,G,R} frame-buffer writes in raster order,
// resynchronising on an inter-byte timeout or an explicit frame_sync.
module pixel_byte_assembler #(
    parameter int H_RES          = 320,
    parameter int V_RES          = 240,
    parameter int ADDR_W         = 17,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    pixel_byte_assembler_if.slave         bus
);
    localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_EXP   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        PH_R,
        PH_G,
        PH_B
    } phase_e;

    phase_e            phase_q, phase_d;
    logic [7:0]        r_q, r_d;
    logic [7:0]        g_q, g_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    always_comb begin
        phase_d      = phase_q;
        r_d          = r_q;
        g_d          = g_q;
        pix_d        = pix_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;

        if (bus.frame_sync) begin
            // Sync is applied before a coincident byte, which then becomes R of pixel 0.
            pix_d   = '0;
            cnt_d   = '0;
            phase_d = PH_R;
            if (bus.rx_valid) begin
                r_d     = bus.rx_data;
                phase_d = PH_G;
            end
        end else if (bus.rx_valid) begin
            cnt_d = '0;
            unique case (phase_q)
                PH_R: begin
                    r_d     = bus.rx_data;
                    phase_d = PH_G;
                end
                PH_G: begin
                    g_d     = bus.rx_data;
                    phase_d = PH_B;
                end
                PH_B: begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = pix_q;
                    wr_data_d    = {bus.rx_data, g_q, r_q};
                    frame_done_d = (pix_q == LAST_ADDR);
                    pix_d        = (pix_q == LAST_ADDR) ? '0 : pix_q + 1'b1;
                    phase_d      = PH_R;
                end
                default: phase_d = PH_R;
            endcase
        end else if (phase_q != PH_R || pix_q != '0) begin
            // The idle cycle that would bring the count to the limit performs the resync.
            if (cnt_q >= CNT_EXP) begin
                cnt_d   = CNT_MAX;
                phase_d = PH_R;
                pix_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        busy_d = (phase_d != PH_R);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= PH_R;
            r_q          <= '0;
            g_q          <= '0;
            pix_q        <= '0;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            r_q          <= r_d;
            g_q          <= g_d;
            pix_q        <= pix_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_pixel_byte_assembler.sv
// Bench for pixel_byte_assembler on a reduced 8x4 frame with a short timeout.
module tb_pixel_byte_assembler;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int N  = H * V;
    localparam int AW = 5;
    localparam int T  = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pixel_byte_assembler_if #(.ADDR_W(AW)) bus ();

    pixel_byte_assembler #(
        .H_RES(H),
        .V_RES(V),
        .ADDR_W(AW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of bytes for the pixel in progress plus a pixel index.
    logic [7:0] part[$];
    int         m_pix  = 0;
    int         m_idle = 0;
    logic       e_wr   = 1'b0;
    logic       e_fd   = 1'b0;
    logic [31:0] e_addr = 0;
    logic [31:0] e_data = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic [7:0] d, input logic fs);
        e_wr = 1'b0;
        e_fd = 1'b0;
        if (r) begin
            part.delete();
            m_pix = 0; m_idle = 0; e_addr = 0; e_data = 0;
            return;
        end
        if (fs) begin
            part.delete();
            m_pix = 0; m_idle = 0;
        end
        if (v) begin
            m_idle = 0;
            part.push_back(d);
            if (part.size() == 3) begin
                e_wr   = 1'b1;
                e_addr = m_pix;
                e_data = {8'h00, part[2], part[1], part[0]};
                e_fd   = (m_pix == N - 1);
                m_pix  = (m_pix + 1) % N;
                part.delete();
            end
        end else if (!fs && (part.size() != 0 || m_pix != 0)) begin
            m_idle++;
            if (m_idle >= T) begin
                part.delete();
                m_pix = 0;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic fs);
        @(negedge clk);
        rst            = r;
        bus.rx_valid   = v;
        bus.rx_data    = d;
        bus.frame_sync = fs;
        model(r, v, d, fs);
        @(posedge clk);
        #1;
        chk("wr_en", {31'd0, bus.wr_en}, {31'd0, e_wr});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, e_fd});
        chk("busy", {31'd0, bus.busy}, {31'd0, part.size() != 0});
        chk("wr_addr", {27'd0, bus.wr_addr}, e_addr);
        chk("wr_data", {8'd0, bus.wr_data}, e_data);
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_pix_rand();
        for (int i = 0; i < 3; i++) send(8'($urandom));
    endtask

    int fd_seen;

    initial begin
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.frame_sync = 1'b0;

        // Reset state
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        idle(1);

        // First pixel: 11,22,33 -> addr 0, data 332211
        send(8'h11); send(8'h22); send(8'h33);
        chk("first_addr", {27'd0, bus.wr_addr}, 32'd0);
        chk("first_data", {8'd0, bus.wr_data}, 32'h332211);
        idle(2);

        // Whole frame with random gaps, wrapping back to pixel 0
        fd_seen = 0;
        for (int p = 0; p < N + 2; p++) begin
            for (int b = 0; b < 3; b++) begin
                send(8'($urandom));
                if (bus.frame_done) fd_seen++;
                idle($urandom_range(0, 2));
            end
        end
        chk("frame_done_count", fd_seen, 32'd1);

        // Inter-byte timeout drops the partial pixel and rewinds the address
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        send_pix_rand(); send_pix_rand();
        send(8'hAA); send(8'hBB);
        idle(T + 3);
        chk("timeout_busy", {31'd0, bus.busy}, 32'd0);
        send(8'h01); send(8'h02); send(8'h03);
        chk("timeout_addr", {27'd0, bus.wr_addr}, 32'd0);
        chk("timeout_data", {8'd0, bus.wr_data}, 32'h030201);

        // frame_sync coincident with the R byte of the next pixel
        for (int i = 0; i < 5; i++) send_pix_rand();
        cyc(1'b0, 1'b1, 8'h44, 1'b1);
        send(8'h55); send(8'h66);
        chk("sync_addr", {27'd0, bus.wr_addr}, 32'd0);
        chk("sync_data", {8'd0, bus.wr_data}, 32'h665544);

        // frame_sync in the cycle the B-write is issued: write still appears
        send_pix_rand(); send_pix_rand();
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        send(8'h07); send(8'h08); send(8'h09);
        chk("sync_wr_addr", {27'd0, bus.wr_addr}, 32'd0);

        // Reset after the 2nd byte of pixel 7
        for (int i = 0; i < 6; i++) send_pix_rand();
        send(8'hE1); send(8'hE2);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        send(8'hC1); send(8'hC2); send(8'hC3);
        chk("rst_addr", {27'd0, bus.wr_addr}, 32'd0);
        chk("rst_data", {8'd0, bus.wr_data}, 32'hC3C2C1);

        // Byte on the exact expiry cycle is accepted
        send_pix_rand(); send_pix_rand();
        send(8'hD1);
        idle(T - 1);
        send(8'hD2); send(8'hD3);
        chk("exact_addr", {27'd0, bus.wr_addr}, 32'd3);
        chk("exact_data", {8'd0, bus.wr_data}, 32'hD3D2D1);

        // One cycle later it has already expired
        send(8'hF1);
        idle(T);
        send(8'hF2); send(8'hF3); send(8'hF4);
        chk("late_addr", {27'd0, bus.wr_addr}, 32'd0);
        chk("late_data", {8'd0, bus.wr_data}, 32'hF4F3F2);

        // Random mix of bytes, gaps, long stalls and syncs
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 60)      send(8'($urandom));
            else if (sel < 62) cyc(1'b0, $urandom_range(0, 1) == 1, 8'($urandom), 1'b1);
            else if (sel < 64) idle($urandom_range(T - 2, T + 1));
            else if (sel < 65) cyc(1'b1, 1'b0, 8'h00, 1'b0);
            else               idle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
